// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter that sequences the 4:1 mux.
// Lock/burst support is compiled in with the MUX_ARB_LOCK_EN macro.
package mux_arb_pkg;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned IDX_W = 2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Mux select pins ordered {addr0, addr1}: addr0 is the index MSB.
   function automatic logic [1:0] idx_to_sel(input logic [IDX_W-1:0] idx);
      return {idx[1], idx[0]};
   endfunction

   function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      return NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod 4.
module mux_arb_rr_pick
   import mux_arb_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] win_idx,
   output logic             any_req
);

   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      win_idx = '0;
      found   = 1'b0;
      cand    = '0;
      any_req = |req;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDX_W'(ptr + IDX_W'(k));
         if (!found && req[cand]) begin
            win_idx = cand;
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select with a valid/ready output handshake.
// Define MUX_ARB_LOCK_EN to let a granted requester hold the mux for up to MAX_BURST beats.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned PTR_RESET = 0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] lock,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [NREQ-1:0] grant,
   output logic            addr0,
   output logic            addr1,
   output logic            busy
);

   arb_state_e       state_q, state_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0] sel_q, sel_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   logic [IDX_W-1:0] next_ptr;
   logic [IDX_W-1:0] pick_ptr;
   logic [IDX_W-1:0] win_idx;
   logic             any_req;
   logic             xfer;
   logic             withdraw;
   logic             lock_hold;

`ifdef MUX_ARB_LOCK_EN
   localparam int unsigned BURST_W = 4;
   logic [BURST_W-1:0] burst_q, burst_d;

   assign lock_hold = lock[sel_q] && (burst_q < BURST_W'(MAX_BURST - 1));
`else
   logic unused_lock;

   assign unused_lock = ^lock;
   assign lock_hold   = 1'b0;
`endif

   assign next_ptr = IDX_W'(sel_q + 1'b1);
   // In GRANT the picker looks ahead with the rotated pointer so a release re-arbitrates without a bubble.
   assign pick_ptr = (state_q == GRANT) ? next_ptr : ptr_q;
   assign xfer     = out_valid_q & out_ready;
   assign withdraw = (state_q == GRANT) & ~xfer & ~req[sel_q];

   mux_arb_rr_pick u_pick (
      .req     (req),
      .ptr     (pick_ptr),
      .win_idx (win_idx),
      .any_req (any_req)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      sel_d       = sel_q;
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;

      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d     = GRANT;
               grant_d     = idx_to_onehot(win_idx);
               sel_d       = win_idx;
               out_valid_d = 1'b1;
               busy_d      = 1'b1;
            end
         end

         GRANT: begin
            if (xfer && !lock_hold) begin
               ptr_d = next_ptr;
               if (any_req) begin
                  grant_d = idx_to_onehot(win_idx);
                  sel_d   = win_idx;
               end else begin
                  state_d     = IDLE;
                  grant_d     = '0;
                  out_valid_d = 1'b0;
                  busy_d      = 1'b0;
               end
            end else if (withdraw) begin
               ptr_d       = next_ptr;
               state_d     = IDLE;
               grant_d     = '0;
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
            end
         end

         default: begin
            state_d     = IDLE;
            grant_d     = '0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

`ifdef MUX_ARB_LOCK_EN
   // Burst count advances on locked beats and clears on any release or withdrawal.
   always_comb begin
      burst_d = burst_q;
      if (xfer && lock_hold) begin
         burst_d = BURST_W'(burst_q + 1'b1);
      end else if (xfer || withdraw) begin
         burst_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         burst_q <= '0;
      end else begin
         burst_q <= burst_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         sel_q       <= '0;
         ptr_q       <= IDX_W'(PTR_RESET);
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         sel_q       <= sel_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign grant          = grant_q;
   assign {addr0, addr1} = idx_to_sel(sel_q);
   assign out_valid      = out_valid_q;
   assign busy           = busy_q;

endmodule
